// File: rtl/irq_ctrl.sv
// irq_ctrl - programmable interrupt controller with an NMI slave register port.
//
// Samples up to IRQ_NUM raw request lines and applies per-line polarity and
// edge/level selection. Edge events are latched as pending. The pending lines
// are masked by an enable register and drive the core's interrupt vector.
//
// Configuration macro:
//   IRQ_CTRL_SYNC_EN  defined   : 2-flop synchroniser plus a sample register
//                                 on every raw line (for asynchronous sources)
//                     undefined : a single sample register (synchronous sources)
//
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   irq_raw_i    raw request lines [IRQ_NUM-1:0]
//   nmi_valid_i  NMI request valid, held by the master until nmi_ready_o
//   nmi_addr_i   byte address, bits [4:2] select the register
//   nmi_wdata_i  write data
//   nmi_wstrb_i  byte write strobes, all zero means read
//   nmi_rdata_o  read data, zero whenever nmi_ready_o is low
//   nmi_ready_o  one-cycle response strobe
//   irq_o        pending & enable, zero-extended to 32 bits
//   irq_any_o    OR-reduction of irq_o
//
// Register map (word offsets): 0x00 ENABLE, 0x04 TRIG (1 = edge),
// 0x08 POL (1 = active-low/falling), 0x0C PENDING (W1C), 0x10 STATUS,
// 0x14 ID (index+1 of lowest STATUS bit, 0 if none), 0x18/0x1C read 0.

module irq_ctrl #(
   parameter int IRQ_NUM = 32
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [IRQ_NUM-1:0] irq_raw_i,
   input  logic               nmi_valid_i,
   input  logic [31:0]        nmi_addr_i,
   input  logic [31:0]        nmi_wdata_i,
   input  logic [3:0]         nmi_wstrb_i,
   output logic [31:0]        nmi_rdata_o,
   output logic               nmi_ready_o,
   output logic [31:0]        irq_o,
   output logic               irq_any_o
);

   logic [IRQ_NUM-1:0] enable_q, trig_q, pol_q, pending_q, prev_q, samp_q;
   logic [IRQ_NUM-1:0] act, edge_set, w1c, pending_d, status, wmask, wbits;
   logic [31:0]        byte_mask, rd_mux;
   logic [5:0]         id;
   logic [2:0]         sel;
   logic               ready_q, wr_en;
   logic               unused_addr;

   function automatic logic [31:0] ext(input logic [IRQ_NUM-1:0] v);
      ext = '0;
      ext[IRQ_NUM-1:0] = v;
   endfunction

   // Input stage producing samp_q, one register or a full synchroniser chain
`ifdef IRQ_CTRL_SYNC_EN
   logic [IRQ_NUM-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         samp_q  <= '0;
      end else begin
         sync1_q <= irq_raw_i;
         sync2_q <= sync1_q;
         samp_q  <= sync2_q;
      end
   end
`else
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         samp_q <= '0;
      end else begin
         samp_q <= irq_raw_i;
      end
   end
`endif

   assign sel         = nmi_addr_i[4:2];
   assign unused_addr = ^{nmi_addr_i[31:5], nmi_addr_i[1:0]};

   // The ready cycle is the one in which the held request is committed;
   // writes land on the edge that ends it
   assign wr_en = ready_q & nmi_valid_i & (|nmi_wstrb_i);

   always_comb begin
      byte_mask = {{8{nmi_wstrb_i[3]}}, {8{nmi_wstrb_i[2]}},
                   {8{nmi_wstrb_i[1]}}, {8{nmi_wstrb_i[0]}}};
      wmask     = byte_mask[IRQ_NUM-1:0];
      wbits     = nmi_wdata_i[IRQ_NUM-1:0] & wmask;
   end

   // Response strobe: never two ready cycles in a row, so a held request
   // cannot be accepted twice
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= nmi_valid_i & ~ready_q;
      end
   end

   // Software configuration registers with per-byte write strobes
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         enable_q <= '0;
         trig_q   <= '0;
         pol_q    <= '0;
      end else if (wr_en) begin
         case (sel)
            3'd0:    enable_q <= (enable_q & ~wmask) | wbits;
            3'd1:    trig_q   <= (trig_q & ~wmask) | wbits;
            3'd2:    pol_q    <= (pol_q & ~wmask) | wbits;
            default: ;
         endcase
      end
   end

   // Level lines follow act directly; edge lines latch rising act and only a
   // W1C clears them, with a simultaneous new edge taking priority
   always_comb begin
      act       = samp_q ^ pol_q;
      edge_set  = act & ~prev_q;
      w1c       = (wr_en && sel == 3'd3) ? wbits : '0;
      pending_d = (trig_q & (edge_set | (pending_q & ~w1c))) | (~trig_q & act);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prev_q    <= '0;
         pending_q <= '0;
      end else begin
         prev_q    <= act;
         pending_q <= pending_d;
      end
   end

   // Lowest-numbered active line wins, so scan from the top down
   always_comb begin
      status = pending_q & enable_q;
      id     = '0;
      for (int i = IRQ_NUM - 1; i >= 0; i--) begin
         if (status[i]) begin
            id = 6'(i + 1);
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (sel)
         3'd0:    rd_mux = ext(enable_q);
         3'd1:    rd_mux = ext(trig_q);
         3'd2:    rd_mux = ext(pol_q);
         3'd3:    rd_mux = ext(pending_q);
         3'd4:    rd_mux = ext(status);
         3'd5:    rd_mux = {26'd0, id};
         default: rd_mux = '0;
      endcase
   end

   assign nmi_ready_o = ready_q;
   assign nmi_rdata_o = ready_q ? rd_mux : 32'd0;
   assign irq_o       = ext(status);
   assign irq_any_o   = |status;

endmodule
